// File: rtl/fpu_wb_pkg.sv
// rtl/fpu_wb_pkg.sv - shared types and constants for the FPU writeback block
package fpu_wb_pkg;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int PKG_AW   = 5;
    localparam int PKG_XLEN = 32;

    typedef enum logic {
        EXC_IDLE = 1'b0,
        EXC_PEND = 1'b1
    } exc_state_t;

    typedef struct packed {
        logic [PKG_AW-1:0]   addr;
        logic [PKG_XLEN-1:0] data;
    } gpr_entry_t;

endpackage

// File: rtl/fpu_wb_fifo.sv
// rtl/fpu_wb_fifo.sv - synchronous FIFO with flush, occupancy count and drop indication
module fpu_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       drop
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_writeback.sv
// rtl/fpu_writeback.sv - FPU result writeback: FP regfile write, buffered GPR drain, fflags, exception request
module fpu_writeback
    import fpu_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int XLEN       = 32,
    parameter int FLEN       = 16,
    parameter int AW         = 5
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            fpu_complete,
    input  logic [FLEN-1:0] fpu_result_1,
    input  logic [AW-1:0]   fpu_frd,
    input  logic            fpu_complete_rd,
    input  logic [XLEN-1:0] fpu_result_rd,
    input  logic [AW-1:0]   fpu_rd,
    input  logic [4:0]      sflags,
    input  logic            IV_exception,
    input  logic            flush,
    output logic            frf_we,
    output logic [AW-1:0]   frf_waddr,
    output logic [FLEN-1:0] frf_wdata,
    output logic            gpr_wb_valid,
    input  logic            gpr_wb_ready,
    output logic [AW-1:0]   gpr_wb_addr,
    output logic [XLEN-1:0] gpr_wb_data,
    output logic            fpu_stall,
    input  logic            csr_fflags_we,
    input  logic [4:0]      csr_fflags_wdata,
    output logic [4:0]      fflags,
    output logic            exc_req,
    input  logic            exc_ack,
    output logic            wb_overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          any_cpl;
    logic          fp_wr;
    logic          gpr_push;
    logic          iv_event;
    logic [4:0]    new_flags;
    gpr_entry_t    push_entry;
    gpr_entry_t    head_entry;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          drop;
    exc_state_t    exc_state;
    exc_state_t    exc_next;

    assign any_cpl   = fpu_complete | fpu_complete_rd;
    assign fp_wr     = fpu_complete && !IV_exception && !flush;
    // x0 writes are architecturally discarded, so they never occupy a FIFO slot.
    assign gpr_push  = fpu_complete_rd && !IV_exception && !flush && (fpu_rd != '0);
    assign iv_event  = IV_exception && any_cpl;
    assign new_flags = any_cpl ? sflags : 5'b0;

    assign push_entry.addr = fpu_rd;
    assign push_entry.data = fpu_result_rd;

    fpu_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(gpr_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_l),
        .flush (flush),
        .push  (gpr_push),
        .wdata (push_entry),
        .pop   (gpr_wb_ready),
        .rdata (head_entry),
        .count (count),
        .full  (full),
        .empty (empty),
        .drop  (drop)
    );

    assign gpr_wb_valid = !empty;
    assign gpr_wb_addr  = empty ? '0 : head_entry.addr;
    assign gpr_wb_data  = empty ? '0 : head_entry.data;
    assign fpu_stall    = (count >= CW'(FIFO_DEPTH - 1));

    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            frf_we      <= 1'b0;
            frf_waddr   <= '0;
            frf_wdata   <= '0;
            fflags      <= 5'b0;
            wb_overflow <= 1'b0;
            exc_state   <= EXC_IDLE;
        end else begin
            frf_we <= fp_wr;
            if (fp_wr) begin
                frf_waddr <= fpu_frd;
                frf_wdata <= fpu_result_1;
            end
            // OR-ing after the CSR mux keeps flags raised in the same cycle as a CSR write.
            fflags <= (csr_fflags_we ? csr_fflags_wdata : fflags) | new_flags;
            if (drop) begin
                wb_overflow <= 1'b1;
            end
            exc_state <= exc_next;
        end
    end

    always_comb begin
        exc_next = exc_state;
        exc_req  = 1'b0;
        case (exc_state)
            EXC_IDLE: begin
                if (iv_event) begin
                    exc_next = EXC_PEND;
                end
            end
            EXC_PEND: begin
                exc_req = 1'b1;
                if (exc_ack && !iv_event) begin
                    exc_next = EXC_IDLE;
                end
            end
            default: exc_next = EXC_IDLE;
        endcase
    end

endmodule

// File: doc/fpu_writeback.md
Name: fpu_writeback

Overview:
Receiving end of the FPU execution result interface.
- Consumes single-cycle FP results (16-bit) and integer-destination results (32-bit) with their completion pulses, exception-flag and invalid-operation outputs.
- Writes FP results to the FP register file; buffers integer results in a small FIFO and drains them to the GPR write port over a valid/ready handshake.
- Accumulates sticky fflags and raises an illegal/invalid exception request held until acknowledged.

Parameters:
FIFO_DEPTH, 4, GPR-result buffer entries (power of two, >=2)
XLEN, 32, integer result width
FLEN, 16, FP result width
AW, 5, register address width

Ports:
clk  input  1  clock
rst_l  input  1  reset, asynchronous, active-high (1 = reset)
fpu_complete  input  1  pulse: fpu_result_1 valid this cycle
fpu_result_1  input  FLEN  FP result
fpu_frd  input  AW  FP destination register
fpu_complete_rd  input  1  pulse: fpu_result_rd valid this cycle
fpu_result_rd  input  XLEN  integer result
fpu_rd  input  AW  GPR destination register
sflags  input  5  {NV,DZ,OF,UF,NX}, valid with either completion pulse
IV_exception  input  1  invalid-op exception, valid with either completion pulse
flush  input  1  pipeline flush
frf_we  output  1  FP regfile write enable
frf_waddr  output  AW  FP regfile write address
frf_wdata  output  FLEN  FP regfile write data
gpr_wb_valid  output  1  GPR write request
gpr_wb_ready  input  1  GPR port accepts request
gpr_wb_addr  output  AW  GPR write address
gpr_wb_data  output  XLEN  GPR write data
fpu_stall  output  1  back-pressure to issue
csr_fflags_we  input  1  CSR write of fflags
csr_fflags_wdata  input  5  CSR write data
fflags  output  5  sticky accrued flags
exc_req  output  1  exception request to trap logic
exc_ack  input  1  trap logic acknowledge
wb_overflow  output  1  sticky FIFO overflow error

Behaviour:
- Reset values: all outputs 0; FIFO empty; exception FSM in IDLE.
- FP path: fpu_complete && !IV_exception && !flush -> next cycle frf_we=1 with registered address and data. Latency 1. frf_we is a single-cycle pulse.
- GPR push: fpu_complete_rd && !IV_exception && !flush && fpu_rd!=0 pushes {fpu_rd, fpu_result_rd}. rd==0 is discarded and never pushed.
- GPR drain: gpr_wb_valid = FIFO non-empty; addr/data = head entry, registered outputs. Pop on gpr_wb_valid && gpr_wb_ready.
- Push into an empty FIFO -> gpr_wb_valid in the next cycle (latency 1).
- Once asserted, valid/addr/data are held stable until accepted.
- Push and pop in the same cycle when full: allowed; count unchanged.
- Push when full without pop: entry dropped; wb_overflow set sticky until reset.
- fpu_stall = (count >= FIFO_DEPTH-1), combinational from count.
- Both completion pulses in the same cycle: both paths proceed independently.
- Flags:
  - new = sflags when (fpu_complete | fpu_complete_rd), else 0.
  - fflags <= (csr_fflags_we ? csr_fflags_wdata : fflags) | new. A CSR write loses no same-cycle flag.
  - Flags accumulate even when IV_exception is set or flush is high.
- Exception FSM:
  - IDLE -> PEND on IV_exception with any completion pulse; exc_req=1 in PEND.
  - PEND -> IDLE on exc_ack.
  - A new IV in PEND is absorbed; no queueing.
  - exc_ack in IDLE is ignored.
  - IV and exc_ack in the same cycle while PEND: stay PEND.
- Flush: empties the FIFO (pointers and count to 0) and drops same-cycle completions. gpr_wb_valid is 0 the next cycle. fflags, exception FSM and wb_overflow are unaffected.
- Asynchronous reset mid-transfer: FIFO content is lost; outputs go to 0 immediately.

Decomposition:
- Shared package fpu_wb_pkg:
  - flag bit index constants NV=4, DZ=3, OF=2, UF=1, NX=0
  - exception FSM state enum {EXC_IDLE, EXC_PEND}
  - GPR entry struct {addr, data}
- One sub-module: fpu_wb_fifo, a parameterised synchronous FIFO with flush, count, full and empty.

Test Plan:
- FP write: fpu_complete=1, fpu_frd=3, fpu_result_1=16'h3C00, sflags=0 -> next cycle frf_we=1, frf_waddr=3, frf_wdata=16'h3C00; fflags=0.
- GPR back-pressure: 4 pushes (rd=1..4, data 32'h10..13) with gpr_wb_ready=0 -> fpu_stall=1 after the 3rd push. Fifth push sets wb_overflow=1. Raising ready drains rd 1..4 in order, one per cycle.
- x0 discard: fpu_complete_rd=1 with fpu_rd=0, data 32'hDEAD -> gpr_wb_valid remains 0; FIFO count=0.
- Flag/CSR collision: fflags=5'b00001, same cycle csr_fflags_we=1 with wdata=0 and sflags=5'b00100 on a completion -> fflags=5'b00100.
- Exception: IV_exception=1, sflags=5'b10000 with fpu_complete, frd=7 -> no frf_we; exc_req=1 and fflags[4]=1. exc_req stays 1 until exc_ack, then returns to 0 the next cycle.
- Flush mid-drain: 2 entries queued, ready=0, flush=1 together with fpu_complete_rd -> next cycle gpr_wb_valid=0, count=0; the new result is not written.
